// File: rtl/counter64_pkg.sv
// Shared constants, FSM state types and write payload for the counter64 AXI4-Lite slave.
package counter64_pkg;

  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_ADDR_W = 4;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;
  localparam int unsigned AXI_PROT_W = 3;
  localparam int unsigned AXI_RESP_W = 2;
  localparam int unsigned REG_IDX_W  = 2;
  localparam int unsigned CNT_OUT_W  = 64;

  localparam logic [REG_IDX_W-1:0] REG_CTRL    = 2'd0;
  localparam logic [REG_IDX_W-1:0] REG_SCRATCH = 2'd1;
  localparam logic [REG_IDX_W-1:0] REG_CNT_LO  = 2'd2;
  localparam logic [REG_IDX_W-1:0] REG_CNT_HI  = 2'd3;

  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_CLR_BIT = 1;
  localparam int unsigned CTRL_OVF_BIT = 8;

  localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_GOTA = 2'd1,
    W_GOTD = 2'd2,
    W_RESP = 2'd3
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } r_state_t;

  typedef struct packed {
    logic [REG_IDX_W-1:0]  idx;
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STRB_W-1:0] strb;
  } wr_req_t;

  // Counter words are read-only; writes to them are rejected.
  function automatic logic is_ro_reg(input logic [REG_IDX_W-1:0] idx);
    return (idx == REG_CNT_LO) || (idx == REG_CNT_HI);
  endfunction

endpackage

// File: rtl/counter64_axil_slave_if.sv
// AXI4-Lite channel bundle between the PS/VIP master and the counter64 slave.
interface counter64_axil_slave_if;
  import counter64_pkg::*;

  logic [AXI_ADDR_W-1:0] awaddr;
  logic [AXI_PROT_W-1:0] awprot;
  logic                  awvalid;
  logic                  awready;
  logic [AXI_DATA_W-1:0] wdata;
  logic [AXI_STRB_W-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [AXI_RESP_W-1:0] bresp;
  logic                  bvalid;
  logic                  bready;
  logic [AXI_ADDR_W-1:0] araddr;
  logic [AXI_PROT_W-1:0] arprot;
  logic                  arvalid;
  logic                  arready;
  logic [AXI_DATA_W-1:0] rdata;
  logic [AXI_RESP_W-1:0] rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/counter64_core.sv
// Free-running wrap-around cycle counter with synchronous clear and sticky overflow flag.
module counter64_core #(
  parameter int unsigned COUNT_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   clr,
  input  logic                   ovf_clr,
  output logic [COUNT_WIDTH-1:0] count_o,
  output logic                   ovf
);

  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;
  logic                   ovf_q;
  logic                   ovf_d;
  logic                   wrap_c;

  // Clear beats enable; a wrap sets OVF even if it is being cleared this cycle.
  always_comb begin
    count_d = count_q;
    wrap_c  = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + COUNT_WIDTH'(1);
      wrap_c  = &count_q;
    end
    ovf_d = (ovf_q & ~ovf_clr) | wrap_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o = count_q;
  assign ovf     = ovf_q;

endmodule

// File: rtl/counter64_axil_slave.sv
// AXI4-Lite register slave for counter64: CTRL, SCRATCH and a coherent lo/hi counter snapshot.
module counter64_axil_slave
  import counter64_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned COUNT_WIDTH        = 64
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  counter64_axil_slave_if.slave s_axi,
  output logic [CNT_OUT_W-1:0]  count_o
);

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic                          awready_q, wready_q, bvalid_q;
  logic [AXI_RESP_W-1:0]         bresp_q;
  logic                          arready_q, rvalid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rd_mux_c;

  logic [REG_IDX_W-1:0]  aw_idx_c, aw_idx_q, ar_idx_c;
  logic [AXI_DATA_W-1:0] w_data_q;
  logic [AXI_STRB_W-1:0] w_strb_q;
  logic                  aw_hs_c, w_hs_c, ar_hs_c;
  logic                  wr_en_c;
  wr_req_t               wr_req_c;

  logic                  en_q, clr_q, ovf_clr_c, ovf;
  logic [AXI_DATA_W-1:0] scratch_q, ctrl_c;
  logic [31:0]           snap_q;
  logic [COUNT_WIDTH-1:0] count;
  logic [CNT_OUT_W-1:0]  count_ext;
  logic                  unused_c;

  assign aw_idx_c = REG_IDX_W'(s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2]);
  assign ar_idx_c = REG_IDX_W'(s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2]);
  assign aw_hs_c  = s_axi.awvalid & awready_q;
  assign w_hs_c   = s_axi.wvalid & wready_q;
  assign ar_hs_c  = s_axi.arvalid & arready_q;
  assign unused_c = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  // Write FSM: the commit happens on whichever handshake completes the AW/W pair.
  always_comb begin
    w_next   = w_state;
    wr_en_c  = 1'b0;
    wr_req_c = '{idx: aw_idx_c, data: s_axi.wdata, strb: s_axi.wstrb};
    case (w_state)
      W_IDLE: begin
        if (aw_hs_c && w_hs_c) begin
          w_next  = W_RESP;
          wr_en_c = 1'b1;
        end else if (aw_hs_c) begin
          w_next = W_GOTA;
        end else if (w_hs_c) begin
          w_next = W_GOTD;
        end
      end
      W_GOTA: begin
        if (w_hs_c) begin
          w_next       = W_RESP;
          wr_en_c      = 1'b1;
          wr_req_c.idx = aw_idx_q;
        end
      end
      W_GOTD: begin
        if (aw_hs_c) begin
          w_next        = W_RESP;
          wr_en_c       = 1'b1;
          wr_req_c.data = w_data_q;
          wr_req_c.strb = w_strb_q;
        end
      end
      W_RESP: begin
        if (s_axi.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_idx_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      w_state   <= w_next;
      awready_q <= (w_next == W_IDLE) || (w_next == W_GOTD);
      wready_q  <= (w_next == W_IDLE) || (w_next == W_GOTA);
      bvalid_q  <= (w_next == W_RESP);
      if (wr_en_c) bresp_q <= is_ro_reg(wr_req_c.idx) ? RESP_SLVERR : RESP_OKAY;
      if (aw_hs_c) aw_idx_q <= aw_idx_c;
      if (w_hs_c) begin
        w_data_q <= s_axi.wdata;
        w_strb_q <= s_axi.wstrb;
      end
    end
  end

  // Register file; CLR is a one-cycle pulse so the clear lands one edge after the write.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      en_q      <= 1'b0;
      clr_q     <= 1'b0;
      scratch_q <= '0;
    end else begin
      clr_q <= 1'b0;
      if (wr_en_c) begin
        case (wr_req_c.idx)
          REG_CTRL: begin
            if (wr_req_c.strb[CTRL_EN_BIT / 8]) begin
              en_q  <= wr_req_c.data[CTRL_EN_BIT];
              clr_q <= wr_req_c.data[CTRL_CLR_BIT];
            end
          end
          REG_SCRATCH: begin
            for (int unsigned b = 0; b < AXI_STRB_W; b++) begin
              if (wr_req_c.strb[b]) scratch_q[8*b +: 8] <= wr_req_c.data[8*b +: 8];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign ovf_clr_c = wr_en_c && (wr_req_c.idx == REG_CTRL) &&
                     wr_req_c.strb[CTRL_OVF_BIT / 8] && wr_req_c.data[CTRL_OVF_BIT];

  counter64_core #(.COUNT_WIDTH(COUNT_WIDTH)) u_core (
    .clk     (S_AXI_ACLK),
    .rst_n   (S_AXI_ARESETN),
    .en      (en_q),
    .clr     (clr_q),
    .ovf_clr (ovf_clr_c),
    .count_o (count),
    .ovf     (ovf)
  );

  assign count_ext = CNT_OUT_W'(count);
  assign count_o   = count_ext;

  // Read FSM and data mux; CNT_HI returns the word captured by the last CNT_LO read.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs_c) r_next = R_RESP;
      R_RESP:  if (s_axi.rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase

    ctrl_c               = '0;
    ctrl_c[CTRL_EN_BIT]  = en_q;
    ctrl_c[CTRL_OVF_BIT] = ovf;

    rd_mux_c = '0;
    case (ar_idx_c)
      REG_CTRL:    rd_mux_c = C_S_AXI_DATA_WIDTH'(ctrl_c);
      REG_SCRATCH: rd_mux_c = C_S_AXI_DATA_WIDTH'(scratch_q);
      REG_CNT_LO:  rd_mux_c = C_S_AXI_DATA_WIDTH'(count_ext[31:0]);
      REG_CNT_HI:  rd_mux_c = C_S_AXI_DATA_WIDTH'(snap_q);
      default:     rd_mux_c = '0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      snap_q    <= '0;
    end else begin
      r_state   <= r_next;
      arready_q <= (r_next == R_IDLE);
      rvalid_q  <= (r_next == R_RESP);
      if (ar_hs_c) rdata_q <= rd_mux_c;
      if (ar_hs_c && (ar_idx_c == REG_CNT_LO)) snap_q <= count_ext[63:32];
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = AXI_DATA_W'(rdata_q);
  assign s_axi.rresp   = RESP_OKAY;

endmodule

// File: tb/tb_counter64_axil_slave.sv
// Directed plus randomized bench for counter64_axil_slave against a time-based counter model.
module tb_counter64_axil_slave;
  import counter64_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  counter64_axil_slave_if s_axi();
  logic [63:0] count;

  counter64_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .COUNT_WIDTH(64)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .s_axi        (s_axi),
    .count_o      (count)
  );

  int total = 0;
  int bad = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: count after edge n is m_base + (n - m_t) while enabled, else m_base.
  bit              m_en = 1'b0;
  bit              m_ovf = 1'b0;
  longint unsigned m_base = 0;
  int unsigned     m_t = 0;
  logic [31:0]     m_scratch = '0;
  logic [31:0]     m_snap = '0;

  function automatic longint unsigned cnt_at(input int unsigned n);
    if (m_en) return m_base + 64'(n - m_t);
    return m_base;
  endfunction

  function automatic void m_ctrl(input int unsigned nw, input logic [31:0] d, input logic [3:0] s);
    longint unsigned c;
    if (s[0]) begin
      c = cnt_at(nw);
      if (d[1]) begin
        m_base = 0;
        m_t    = nw + 1;
      end else begin
        m_base = c;
        m_t    = nw;
      end
      m_en = d[0];
    end
    if (s[1] && d[8]) m_ovf = 1'b0;
  endfunction

  function automatic logic [31:0] m_ctrl_word();
    logic [31:0] w;
    w    = '0;
    w[0] = m_en;
    w[8] = m_ovf;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [3:0] addr, input int hold, output logic [31:0] data,
                    output int unsigned hs);
    int n = 0;
    s_axi.araddr  = addr;
    s_axi.arvalid = 1'b1;
    while (s_axi.arready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("arready_wait", 64'(s_axi.arready), 64'(1));
    @(posedge clk); #1;
    hs = cyc;
    s_axi.arvalid = 1'b0;
    chk("rvalid_rise", 64'(s_axi.rvalid), 64'(1));
    chk("rresp", 64'(s_axi.rresp), 64'(RESP_OKAY));
    data = s_axi.rdata;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("rdata_hold", 64'(s_axi.rdata), 64'(data));
      chk("rvalid_hold", 64'(s_axi.rvalid), 64'(1));
      chk("arready_low", 64'(s_axi.arready), 64'(0));
    end
    s_axi.rready = 1'b1;
    @(posedge clk); #1;
    s_axi.rready = 1'b0;
    chk("rvalid_drop", 64'(s_axi.rvalid), 64'(0));
  endtask

  // mode 0: AW+W together, 1: W first, 2: AW first; gap = cycles between the two handshakes.
  task automatic wr(input logic [3:0] addr, input logic [31:0] d, input logic [3:0] s,
                    input int mode, input int gap, input int hold, input logic [1:0] exp_resp,
                    output int unsigned hs);
    int n = 0;
    logic [1:0] resp;
    s_axi.awaddr = addr;
    s_axi.wdata  = d;
    s_axi.wstrb  = s;
    if (mode == 0) begin
      s_axi.awvalid = 1'b1;
      s_axi.wvalid  = 1'b1;
      while (!(s_axi.awready === 1'b1 && s_axi.wready === 1'b1) && n < 20) begin
        @(posedge clk); #1; n++;
      end
      chk("awwready_wait", 64'(s_axi.awready & s_axi.wready), 64'(1));
      @(posedge clk); #1;
      hs = cyc;
      s_axi.awvalid = 1'b0;
      s_axi.wvalid  = 1'b0;
    end else begin
      if (mode == 1) s_axi.wvalid = 1'b1;
      else           s_axi.awvalid = 1'b1;
      while (((mode == 1) ? s_axi.wready : s_axi.awready) !== 1'b1 && n < 20) begin
        @(posedge clk); #1; n++;
      end
      chk("first_ready_wait", 64'((mode == 1) ? s_axi.wready : s_axi.awready), 64'(1));
      @(posedge clk); #1;
      s_axi.awvalid = 1'b0;
      s_axi.wvalid  = 1'b0;
      for (int k = 0; k < gap; k++) begin
        chk("bvalid_early", 64'(s_axi.bvalid), 64'(0));
        chk("no_second_ready", 64'((mode == 1) ? s_axi.wready : s_axi.awready), 64'(0));
        if (k < gap - 1) begin
          @(posedge clk); #1;
        end
      end
      if (mode == 1) s_axi.awvalid = 1'b1;
      else           s_axi.wvalid = 1'b1;
      n = 0;
      while (((mode == 1) ? s_axi.awready : s_axi.wready) !== 1'b1 && n < 20) begin
        @(posedge clk); #1; n++;
      end
      chk("second_ready_wait", 64'((mode == 1) ? s_axi.awready : s_axi.wready), 64'(1));
      @(posedge clk); #1;
      hs = cyc;
      s_axi.awvalid = 1'b0;
      s_axi.wvalid  = 1'b0;
    end
    chk("bvalid_rise", 64'(s_axi.bvalid), 64'(1));
    chk("bresp", 64'(s_axi.bresp), 64'(exp_resp));
    resp = s_axi.bresp;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("bvalid_hold", 64'(s_axi.bvalid), 64'(1));
      chk("bresp_hold", 64'(s_axi.bresp), 64'(resp));
      chk("aw_w_ready_low", 64'({s_axi.awready, s_axi.wready}), 64'(0));
    end
    s_axi.bready = 1'b1;
    @(posedge clk); #1;
    s_axi.bready = 1'b0;
    chk("bvalid_drop", 64'(s_axi.bvalid), 64'(0));
  endtask

  task automatic force_count(input logic [63:0] v);
    int unsigned hs;
    wr(4'h0, 32'h0, 4'h1, 0, 0, 0, RESP_OKAY, hs);
    m_ctrl(hs, 32'h0, 4'h1);
    @(negedge clk);
    force dut.u_core.count_q = v;
    @(posedge clk); #1;
    release dut.u_core.count_q;
    m_base = v;
    chk("forced_count", count, v);
  endtask

  logic [31:0] d, rnd, exp32;
  logic [3:0]  strb;
  int unsigned hs;

  initial begin
    s_axi.awaddr = '0; s_axi.awprot = '0; s_axi.awvalid = 1'b0;
    s_axi.wdata = '0;  s_axi.wstrb = '0;  s_axi.wvalid = 1'b0; s_axi.bready = 1'b0;
    s_axi.araddr = '0; s_axi.arprot = '0; s_axi.arvalid = 1'b0; s_axi.rready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'({s_axi.awready, s_axi.wready, s_axi.arready}), 64'(0));
    chk("rst_valid", 64'({s_axi.bvalid, s_axi.rvalid}), 64'(0));
    chk("rst_resp", 64'({s_axi.bresp, s_axi.rresp}), 64'(0));
    chk("rst_rdata", 64'(s_axi.rdata), 64'(0));
    chk("rst_count", count, 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int a = 0; a < 4; a++) begin
      rd(4'(a * 4), 0, d, hs);
      chk("reset_reg", 64'(d), 64'(0));
    end

    // Scratch byte strobes and both AW/W orderings.
    wr(4'h4, 32'hDEADBEEF, 4'hF, 0, 0, 5, RESP_OKAY, hs);
    wr(4'h4, 32'h00000011, 4'h1, 1, 3, 0, RESP_OKAY, hs);
    m_scratch = 32'hDEADBE11;
    rd(4'h4, 5, d, hs);
    chk("scratch_strb", 64'(d), 64'(m_scratch));
    wr(4'h5, 32'hA5A5_0000, 4'hC, 2, 3, 2, RESP_OKAY, hs);
    m_scratch[31:16] = 16'hA5A5;
    rd(4'h4, 0, d, hs);
    chk("scratch_aw_first", 64'(d), 64'(m_scratch));

    wr(4'h0, 32'h1, 4'h1, 0, 0, 0, RESP_OKAY, hs);
    m_ctrl(hs, 32'h1, 4'h1);
    repeat (3) @(posedge clk);
    #1;
    chk("count_running", count, cnt_at(cyc));

    wr(4'h8, 32'h1234, 4'hF, 0, 0, 5, RESP_SLVERR, hs);
    chk("ro_write_cnt", count, cnt_at(cyc));
    wr(4'hC, 32'hFFFF, 4'hF, 1, 2, 0, RESP_SLVERR, hs);
    chk("ro_write_cnt_hi", count, cnt_at(cyc));

    for (int it = 0; it < 30; it++) begin
      rnd = $urandom;
      case ($urandom_range(0, 4))
        0: begin
          strb = 4'($urandom_range(1, 15));
          wr({2'b01, 2'($urandom_range(0, 3))}, rnd, strb, int'($urandom_range(0, 2)),
             int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), RESP_OKAY, hs);
          for (int b = 0; b < 4; b++) if (strb[b]) m_scratch[8*b +: 8] = rnd[8*b +: 8];
        end
        1: begin
          if (rnd[0]) begin
            rd({2'b00, 2'(rnd[2:1])}, int'($urandom_range(0, 5)), d, hs);
            chk("rand_ctrl", 64'(d), 64'(m_ctrl_word()));
          end else begin
            rd({2'b01, 2'(rnd[2:1])}, int'($urandom_range(0, 5)), d, hs);
            chk("rand_scratch", 64'(d), 64'(m_scratch));
          end
        end
        2: begin
          rd({2'b10, 2'(rnd[2:1])}, int'($urandom_range(0, 5)), d, hs);
          exp32  = 32'(cnt_at(hs - 1));
          m_snap = 32'(cnt_at(hs - 1) >> 32);
          chk("rand_cnt_lo", 64'(d), 64'(exp32));
        end
        3: begin
          rd({2'b11, 2'(rnd[2:1])}, int'($urandom_range(0, 5)), d, hs);
          chk("rand_cnt_hi", 64'(d), 64'(m_snap));
          chk("rand_count", count, cnt_at(cyc));
        end
        default: begin
          d    = {31'h0, rnd[0]} | (rnd[3] ? 32'h2 : 32'h0);
          strb = {2'b00, rnd[5:4]};
          wr(4'h0, d, strb, int'($urandom_range(0, 2)), int'($urandom_range(1, 3)), 0,
             RESP_OKAY, hs);
          m_ctrl(hs, d, strb);
          @(posedge clk); #1;
          chk("rand_ctrl_cnt", count, cnt_at(cyc));
        end
      endcase
    end

    // Snapshot coherence across a carry into the high word.
    force_count(64'h0000_0001_FFFF_FFF8);
    wr(4'h0, 32'h1, 4'h1, 0, 0, 0, RESP_OKAY, hs);
    m_ctrl(hs, 32'h1, 4'h1);
    rd(4'h8, 0, d, hs);
    exp32  = 32'(cnt_at(hs - 1));
    m_snap = 32'(cnt_at(hs - 1) >> 32);
    chk("snap_lo", 64'(d), 64'(exp32));
    repeat (10) @(posedge clk);
    #1;
    rd(4'hC, 5, d, hs);
    chk("snap_hi", 64'(d), 64'(m_snap));
    chk("snap_live", count, cnt_at(cyc));

    // Wrap, OVF W1C, then CLR+EN restart.
    force_count(64'hFFFF_FFFF_FFFF_FFF0);
    wr(4'h0, 32'h1, 4'h1, 0, 0, 0, RESP_OKAY, hs);
    m_ctrl(hs, 32'h1, 4'h1);
    repeat (30) @(posedge clk);
    #1;
    chk("wrap_count", count, cnt_at(cyc));
    m_ovf = 1'b1;
    rd(4'h0, 0, d, hs);
    chk("ovf_set", 64'(d), 64'(m_ctrl_word()));
    wr(4'h0, 32'h100, 4'h3, 1, 2, 0, RESP_OKAY, hs);
    m_ctrl(hs, 32'h100, 4'h3);
    rd(4'h0, 0, d, hs);
    chk("ovf_clear", 64'(d), 64'(m_ctrl_word()));
    wr(4'h0, 32'h3, 4'h1, 0, 0, 0, RESP_OKAY, hs);
    m_ctrl(hs, 32'h3, 4'h1);
    repeat (4) @(posedge clk);
    #1;
    chk("clr_restart", count, cnt_at(cyc));
    rd(4'h8, 3, d, hs);
    chk("clr_restart_lo", 64'(d), 64'(32'(cnt_at(hs - 1))));
    rd(4'h0, 0, d, hs);
    chk("clr_reads_zero", 64'(d), 64'(m_ctrl_word()));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
